// File: rtl/xeng_stagger_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : xeng_lib_pkg
//  Description : Shared X-engine definitions. This file holds the loader FSM
//                state encodings and the lane-slice helper macro XENG_LANE.
//  Revision    : 1.0  initial release
// ============================================================================

// XENG_LANE selects lane p, which is w bits wide, from a packed vector.
// Lane 0 occupies the least significant bits.
`ifndef XENG_LANE
`define XENG_LANE(vec, p, w) vec[(p)*(w) +: (w)]
`endif

package xeng_lib_pkg;

    // Loader FSM state encodings
    localparam logic [0:0] WAIT_SYNC = 1'b0;
    localparam logic [0:0] FILL      = 1'b1;

endpackage

`default_nettype wire

// File: rtl/xeng_stagger_loader.sv
`default_nettype none
// ============================================================================
//  Module      : xeng_stagger_loader
//  Description : Serial-to-parallel window loader for the X-engine stagger
//                stage. It packs N_STAGES samples into one word, with sample 0
//                in lane 0. Windows are framed by sync_in.
//                When XENG_LOADER_ERR_EN is defined, the module also provides
//                the saturating partial-window error counter err_cnt.
//  Revision    : 1.0  initial release
// ============================================================================

module xeng_stagger_loader
    import xeng_lib_pkg::*;
#(
    parameter int N_STAGES   = 4,
    parameter int BLOCK_SIZE = 8
`ifdef XENG_LOADER_ERR_EN
    ,
    parameter int CNT_W      = 8
`endif
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [BLOCK_SIZE-1:0]          din,
    input  logic                           din_valid,
    input  logic                           sync_in,
    output logic [N_STAGES*BLOCK_SIZE-1:0] dout,
    output logic                           dout_valid,
    output logic                           dout_sync
`ifdef XENG_LOADER_ERR_EN
    ,
    output logic [CNT_W-1:0]               err_cnt
`endif
);

    localparam int              CW        = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
    localparam int              DW        = N_STAGES * BLOCK_SIZE;
    localparam logic [CW-1:0]   LAST_LANE = CW'(N_STAGES - 1);

    logic [0:0]          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                flag_q, flag_d;
    logic [DW-1:0]       asm_q, asm_d;
    logic [DW-1:0]       dout_q;
    logic                dout_valid_q;
    logic                dout_sync_q;

    logic                w_sync_hit;
    logic                w_write;
    logic                w_resync;
    logic                w_complete;
    logic [CW-1:0]       w_wr_idx;
    logic [N_STAGES-1:0] w_lane_we;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WAIT_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: the first qualified sync leaves WAIT_SYNC. FILL is held from then on.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_SYNC: if (din_valid && sync_in) state_d = FILL;
            FILL:      state_d = FILL;
            default:   state_d = WAIT_SYNC;
        endcase
    end

    // FSM outputs: write qualification, target lane, resync detect, completion
    always_comb begin
        w_sync_hit = din_valid && sync_in;
        w_write    = 1'b0;
        w_resync   = 1'b0;
        case (state_q)
            WAIT_SYNC: w_write = w_sync_hit;
            FILL: begin
                w_write  = din_valid;
                // A sync that lands mid-window discards the partial window.
                w_resync = w_sync_hit && (cnt_q != '0);
            end
            default: w_write = 1'b0;
        endcase
        // A sync always targets lane 0. Because of this, completion and sync can
        // only coincide when N_STAGES == 1.
        w_wr_idx   = w_sync_hit ? '0 : cnt_q;
        w_complete = w_write && (w_wr_idx == LAST_LANE);
    end

    // Lane counter and window-sync flag next state
    always_comb begin
        cnt_d  = cnt_q;
        flag_d = flag_q;
        if (w_write) begin
            if (w_complete) begin
                cnt_d  = '0;
                flag_d = 1'b0;
            end else begin
                cnt_d  = w_wr_idx + 1'b1;
                flag_d = w_sync_hit || flag_q;
            end
        end
    end

    // Per-lane write enables decoded from the target lane. Unwritten lanes keep stale data.
    for (genvar p = 0; p < N_STAGES; p++) begin : g_lane
        assign w_lane_we[p] = w_write && (w_wr_idx == CW'(p));
        assign `XENG_LANE(asm_d, p, BLOCK_SIZE) =
            w_lane_we[p] ? din : `XENG_LANE(asm_q, p, BLOCK_SIZE);
    end

    // Datapath registers: the assembly word, the counter, and the output window and strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            flag_q       <= 1'b0;
            asm_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_sync_q  <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            flag_q       <= flag_d;
            asm_q        <= asm_d;
            dout_valid_q <= w_complete;
            dout_sync_q  <= w_complete && (w_sync_hit || flag_q);
            if (w_complete) begin
                dout_q <= asm_d;
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_sync  = dout_sync_q;

`ifdef XENG_LOADER_ERR_EN
    logic [CNT_W-1:0] err_q;

    // Saturating count of partial windows discarded by a resync
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= '0;
        end else if (w_resync && (err_q != '1)) begin
            err_q <= err_q + 1'b1;
        end
    end

    assign err_cnt = err_q;
`endif

endmodule

`default_nettype wire
